// File: rtl/neuron_membrane_discharge_if.sv
// neuron_membrane_discharge_if: handshake and data bundle for one LIF neuron.
// The master side offers currents and accepts spikes; the slave side is the neuron.
interface neuron_membrane_discharge_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_current;
  logic signed [WIDTH-1:0] threshold;
  logic                    spike_valid;
  logic                    spike_ready;
  logic signed [WIDTH-1:0] membrane;

  modport master (
    output in_valid,
    output in_current,
    output threshold,
    output spike_ready,
    input  in_ready,
    input  spike_valid,
    input  membrane
  );

  modport slave (
    input  in_valid,
    input  in_current,
    input  threshold,
    input  spike_ready,
    output in_ready,
    output spike_valid,
    output membrane
  );
endinterface

// File: rtl/neuron_membrane_discharge.sv
// neuron_membrane_discharge: leaky integrate-and-fire membrane with saturating
// integration, optional leak stage and subtractive discharge on spike handshake.
// Optional feature macro: NEURON_MEMBRANE_LEAK_EN (defined = LEAK state present;
// undefined = INTEGRATE decides directly and LEAK_SHIFT is ignored).
// The interface instance must be built with the same WIDTH as this module.
module neuron_membrane_discharge #(
  parameter int WIDTH      = 8,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRACTORY = 2
) (
  input logic                      clk,
  input logic                      reset,
  neuron_membrane_discharge_if.slave bus
);

  localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int CW        = (REFRACTORY > 1) ? $clog2(REFRACTORY) : 1;
  localparam int REFR_LOAD = (REFRACTORY > 0) ? REFRACTORY - 1 : 0;

  typedef enum logic [2:0] {
    IDLE,
    INTEGRATE,
    LEAK,
    FIRE,
    REFRACT
  } state_t;

  state_t                  state_reg, state_next;
  logic signed [WIDTH-1:0] membrane_reg, membrane_next;
  logic signed [WIDTH-1:0] current_reg, current_next;
  logic signed [WIDTH-1:0] threshold_reg, threshold_next;
  logic [CW-1:0]           count_reg, count_next;
  logic signed [WIDTH-1:0] sum;
`ifdef NEURON_MEMBRANE_LEAK_EN
  logic signed [WIDTH-1:0] leaked;
`endif

  // Two's-complement add that clamps instead of wrapping.
  function automatic logic signed [WIDTH-1:0] sat_add(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    r = a + b;
    if ((a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]))
      r = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    return r;
  endfunction

  // Two's-complement subtract that clamps instead of wrapping.
  // Overflow is only possible when the operands have opposite signs.
  function automatic logic signed [WIDTH-1:0] sat_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH-1:0] r;
    r = a - b;
    if ((a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]))
      r = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
    return r;
  endfunction

  // State and datapath registers; reset drops any pending spike.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      membrane_reg  <= '0;
      current_reg   <= '0;
      threshold_reg <= '0;
      count_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      membrane_reg  <= membrane_next;
      current_reg   <= current_next;
      threshold_reg <= threshold_next;
      count_reg     <= count_next;
    end
  end

  // Next-state and datapath update for the integrate/leak/fire/refractory cycle.
  always_comb begin
    state_next     = state_reg;
    membrane_next  = membrane_reg;
    current_next   = current_reg;
    threshold_next = threshold_reg;
    count_next     = count_reg;
    sum            = sat_add(membrane_reg, current_reg);
`ifdef NEURON_MEMBRANE_LEAK_EN
    leaked         = sat_sub(membrane_reg, membrane_reg >>> LEAK_SHIFT);
`endif

    case (state_reg)
      IDLE: begin
        // Operands are captured only here so later input changes are ignored.
        if (bus.in_valid) begin
          current_next   = bus.in_current;
          threshold_next = bus.threshold;
          state_next     = INTEGRATE;
        end
      end
      INTEGRATE: begin
        membrane_next = sum;
`ifdef NEURON_MEMBRANE_LEAK_EN
        state_next    = LEAK;
`else
        state_next    = (sum >= threshold_reg) ? FIRE : IDLE;
`endif
      end
`ifdef NEURON_MEMBRANE_LEAK_EN
      LEAK: begin
        membrane_next = leaked;
        state_next    = (leaked >= threshold_reg) ? FIRE : IDLE;
      end
`endif
      FIRE: begin
        // Spike is held until accepted; discharge happens on the accept edge.
        if (bus.spike_ready) begin
          membrane_next = sat_sub(membrane_reg, threshold_reg);
          if (REFRACTORY > 0) begin
            state_next = REFRACT;
            count_next = CW'(REFR_LOAD);
          end else begin
            state_next = IDLE;
          end
        end
      end
      REFRACT: begin
        if (count_reg == '0)
          state_next = IDLE;
        else
          count_next = count_reg - CW'(1);
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = (state_reg == IDLE);
  assign bus.spike_valid = (state_reg == FIRE);
  assign bus.membrane    = membrane_reg;

endmodule

// File: tb/tb_neuron_membrane_discharge.sv
// tb_neuron_membrane_discharge: directed stimulus against an arithmetic
// transaction model of the LIF neuron, checked every cycle, plus literal
// expectations taken from hand-worked examples.
module tb_neuron_membrane_discharge;

  localparam int W    = 8;
  localparam int LS   = 2;
  localparam int REFR = 2;

  logic clk;
  logic reset;

  neuron_membrane_discharge_if #(.WIDTH(W)) bus ();

  neuron_membrane_discharge #(
    .WIDTH(W),
    .LEAK_SHIFT(LS),
    .REFRACTORY(REFR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  bit check_en;

  // Expected observable state of the neuron
  int exp_m;
  bit exp_ready;
  bit exp_spike;
  int thr;

  function automatic int clamp(int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // Pick the literal that applies to the current build
  function automatic int lit(int no_leak, int with_leak);
`ifdef NEURON_MEMBRANE_LEAK_EN
    return with_leak;
`else
    return no_leak;
`endif
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("membrane", int'(bus.membrane), exp_m);
      chk("in_ready", int'(bus.in_ready), int'(exp_ready));
      chk("spike_valid", int'(bus.spike_valid), int'(exp_spike));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one current; model predicts membrane and decision after it
  task automatic send(int cur);
    chk("send_in_ready", int'(bus.in_ready), 1);
    bus.in_valid   = 1'b1;
    bus.in_current = W'(cur);
    bus.threshold  = W'(thr);
    tick();                         // accept edge
    bus.in_valid   = 1'b0;
    bus.in_current = 8'sd77;        // must not affect the captured operands
    bus.threshold  = -8'sd100;
    exp_ready = 1'b0;
    tick();                         // integrate edge
    exp_m = clamp(exp_m + cur);
`ifdef NEURON_MEMBRANE_LEAK_EN
    tick();                         // leak edge
    exp_m = clamp(exp_m - (exp_m >>> LS));
`endif
    exp_spike = (exp_m >= thr);
    exp_ready = !exp_spike;
    $display("txn send cur=%0d thr=%0d membrane=%0d spike=%0d", cur, thr, exp_m, exp_spike);
  endtask

  // Hold the spike for some cycles, then accept it and ride out refractory
  task automatic fire(int hold);
    for (int i = 0; i < hold; i++) begin
      bus.threshold  = 8'sd1;
      bus.in_current = -8'sd5;
      bus.in_valid   = 1'b1;
      tick();
    end
    bus.in_valid    = 1'b0;
    bus.spike_ready = 1'b1;
    tick();                         // spike handshake edge
    bus.spike_ready = 1'b0;
    exp_m     = clamp(exp_m - thr);
    exp_spike = 1'b0;
    if (REFR > 0) begin
      exp_ready = 1'b0;
      for (int i = 0; i < REFR - 1; i++) tick();
      tick();
    end
    exp_ready = 1'b1;
    $display("txn fire hold=%0d membrane=%0d", hold, exp_m);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    exp_m = 0; exp_ready = 1'b1; exp_spike = 1'b0;
    reset = 1'b0;
    $display("txn reset");
  endtask

  initial begin
    checks = 0; errors = 0; check_en = 1'b0;
    thr = 40;
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_current = 8'sd50; bus.threshold = 8'sd40;
    bus.spike_ready = 1'b0;
    exp_m = 0; exp_ready = 1'b1; exp_spike = 1'b0;

    // Reset for two cycles with in_valid high
    tick();
    tick();
    check_en = 1'b1;
    chk("reset_membrane", int'(bus.membrane), 0);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_spike", int'(bus.spike_valid), 0);
    reset = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("reset_no_accept", int'(bus.in_ready), 1);
    $display("txn reset_release");

    // Sub-threshold integration
    send(20);
    chk("lit_first", int'(bus.membrane), lit(20, 15));
    chk("lit_first_ready", int'(bus.in_ready), 1);

    // Supra-threshold, spike held 3 cycles then discharged
    send(100);
    chk("lit_second", int'(bus.membrane), lit(120, 87));
    chk("lit_second_spike", int'(bus.spike_valid), 1);
    fire(3);
    chk("lit_discharge", int'(bus.membrane), lit(80, 47));

    // Single-cycle decision example
    do_reset();
    send(50);
    chk("lit_fifty", int'(bus.membrane), lit(50, 38));
    if (exp_spike) fire(0);
    chk("lit_fifty_after", int'(bus.membrane), lit(10, 38));

    // Negative saturation
    do_reset();
    send(-128);
    chk("lit_neg1", int'(bus.membrane), lit(-128, -96));
    send(-128);
    chk("lit_neg2", int'(bus.membrane), lit(-128, -96));
    send(-1);
    send(127);
    send(127);
    if (exp_spike) fire(1);

    // Positive saturation at the top of the range
    do_reset();
    thr = 127;
    send(100);
    send(100);
    chk("lit_pos_sat", int'(bus.membrane), lit(127, 96));
    if (exp_spike) fire(1);
    thr = 40;

    // Reset while a spike is pending
    do_reset();
    send(60);
    chk("lit_pre_rst_spike", int'(bus.spike_valid), 1);
    tick();
    do_reset();
    chk("rst_fire_spike", int'(bus.spike_valid), 0);
    chk("rst_fire_membrane", int'(bus.membrane), 0);
    chk("rst_fire_ready", int'(bus.in_ready), 1);
    tick();
    send(10);

    tick();
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
